// File: rtl/gelato_ibuffer_pkg.sv
// Shared types and sizing for the per-warp instruction buffer.
// The decoded-instruction struct is the common currency between decode and issue.
package gelato_ibuffer_pkg;

    localparam int IB_NUM_WARPS = 8;
    localparam int IB_DEPTH     = 2;
    localparam int IB_WID_W     = (IB_NUM_WARPS > 1) ? $clog2(IB_NUM_WARPS) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  opcode;
        logic [5:0]  rd;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [3:0]  fu;
        logic        wr_en;
        logic        last;
        logic [31:0] imm;
    } inst_t;

    localparam int IB_INST_WIDTH = $bits(inst_t);

    function automatic logic [IB_WID_W-1:0] warp_inc(input logic [IB_WID_W-1:0] w);
        if (w == IB_WID_W'(IB_NUM_WARPS - 1)) begin
            return {IB_WID_W{1'b0}};
        end else begin
            return w + IB_WID_W'(1);
        end
    endfunction

endpackage

// File: rtl/gelato_ibuffer_if.sv
// Fetch/decode/issue-facing bundle of the instruction buffer.
// The buffer itself takes the slave view; the surrounding pipeline drives the master view.
interface gelato_ibuffer_if;
    import gelato_ibuffer_pkg::*;

    logic                    rsv_valid;
    logic [IB_WID_W-1:0]     rsv_warp_id;
    logic [IB_NUM_WARPS-1:0] warp_full;
    logic                    in_valid;
    logic [IB_WID_W-1:0]     in_warp_id;
    inst_t                   in_inst;
    logic                    flush_valid;
    logic [IB_WID_W-1:0]     flush_warp_id;
    logic                    out_valid;
    logic [IB_WID_W-1:0]     out_warp_id;
    inst_t                   out_inst;
    logic                    out_ready;

    modport master (
        output rsv_valid, rsv_warp_id, in_valid, in_warp_id, in_inst,
               flush_valid, flush_warp_id, out_ready,
        input  warp_full, out_valid, out_warp_id, out_inst
    );

    modport slave (
        input  rsv_valid, rsv_warp_id, in_valid, in_warp_id, in_inst,
               flush_valid, flush_warp_id, out_ready,
        output warp_full, out_valid, out_warp_id, out_inst
    );

endinterface

// File: rtl/gelato_ibuffer_chk.sv
// Protocol checks for the instruction buffer: no reservation on a full warp,
// no arrival for a warp that holds no credit. Both are ignored by the datapath.
module gelato_ibuffer_chk
    import gelato_ibuffer_pkg::*;
(
    input logic                    clk,
    input logic                    rst_n,
    input logic                    rdy,
    input logic                    rsv_valid,
    input logic [IB_WID_W-1:0]     rsv_warp_id,
    input logic                    in_valid,
    input logic [IB_WID_W-1:0]     in_warp_id,
    input logic [IB_NUM_WARPS-1:0] warp_full,
    input logic [IB_NUM_WARPS-1:0] no_credit
);

    a_rsv_on_full: assert property (@(posedge clk) disable iff (!rst_n)
        (rdy && rsv_valid) |-> !warp_full[rsv_warp_id])
        else $warning("gelato_ibuffer: reservation on full warp %0d ignored", rsv_warp_id);

    a_arrival_credit: assert property (@(posedge clk) disable iff (!rst_n)
        (rdy && in_valid) |-> !no_credit[in_warp_id])
        else $warning("gelato_ibuffer: arrival without credit on warp %0d ignored", in_warp_id);

endmodule

// File: rtl/gelato_ibuffer_queue.sv
// One warp's instruction FIFO with fetch credits and a stale-arrival drop counter.
// Reservations claim a slot at fetch time, so an accepted arrival always finds room.
module gelato_ibuffer_queue
    import gelato_ibuffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  logic  i_rsv,
    input  logic  i_wr,
    input  inst_t i_data,
    input  logic  i_rd,
    input  logic  i_flush,
    output inst_t o_head,
    output logic  o_empty,
    output logic  o_full,
    output logic  o_no_credit
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reserved;
    logic [CNT_W-1:0] r_drop;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    inst_t            r_mem [DEPTH];

    logic             w_rsv_ok;
    logic             w_arr_ok;
    logic             w_drop_hit;
    logic             w_write;
    logic             w_read;
    logic [CNT_W-1:0] w_rsv_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign o_head      = r_mem[r_head];
    assign o_empty     = (r_count == CNT_ZERO);
    assign o_no_credit = (r_reserved == CNT_ZERO);
    assign o_full      = (({1'b0, r_count} + {1'b0, r_reserved}) == {1'b0, CNT_DEPTH});

    // Qualify requests; illegal reservations/arrivals and a write into a full FIFO are ignored
    always_comb begin
        w_rsv_ok   = i_rsv && !o_full;
        w_arr_ok   = i_wr && (r_reserved != CNT_ZERO);
        w_drop_hit = w_arr_ok && (r_drop != CNT_ZERO);
        w_write    = w_arr_ok && !w_drop_hit && !i_flush && (r_count != CNT_DEPTH);
        w_read     = i_rd && !i_flush && (r_count != CNT_ZERO);
        w_rsv_next = r_reserved + CNT_W'(w_rsv_ok) - CNT_W'(w_arr_ok);
    end

    // Queue state; a flush turns every still-outstanding credit into a pending drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= CNT_ZERO;
            r_reserved <= CNT_ZERO;
            r_drop     <= CNT_ZERO;
            r_head     <= {PTR_W{1'b0}};
            r_tail     <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= inst_t'({IB_INST_WIDTH{1'b0}});
            end
        end else if (i_en) begin
            r_reserved <= w_rsv_next;
            if (i_flush) begin
                r_count <= CNT_ZERO;
                r_head  <= {PTR_W{1'b0}};
                r_tail  <= {PTR_W{1'b0}};
                r_drop  <= w_rsv_next;
            end else begin
                if (w_write) begin
                    r_mem[r_tail] <= i_data;
                    r_tail        <= ptr_inc(r_tail);
                end
                if (w_read) begin
                    r_head <= ptr_inc(r_head);
                end
                r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_read);
                r_drop  <= r_drop - CNT_W'(w_drop_hit);
            end
        end
    end

endmodule

// File: rtl/gelato_ibuffer.sv
// Per-warp instruction buffer: NUM_WARPS credit-managed FIFOs feeding a single
// round-robin issue port. rdy low freezes all state and hides the issue port.
module gelato_ibuffer
    import gelato_ibuffer_pkg::*;
#(
    parameter int DEPTH = IB_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    input logic             rdy,
    gelato_ibuffer_if.slave bus
);

    logic [IB_NUM_WARPS-1:0] w_rsv;
    logic [IB_NUM_WARPS-1:0] w_wr;
    logic [IB_NUM_WARPS-1:0] w_rd;
    logic [IB_NUM_WARPS-1:0] w_flush;
    logic [IB_NUM_WARPS-1:0] w_empty;
    logic [IB_NUM_WARPS-1:0] w_full;
    logic [IB_NUM_WARPS-1:0] w_no_credit;
    logic [IB_NUM_WARPS-1:0] w_cand;
    inst_t                   w_head [IB_NUM_WARPS];

    logic [IB_WID_W-1:0]     r_rr;
    logic                    w_found;
    logic [IB_WID_W-1:0]     w_win;
    logic [IB_WID_W-1:0]     w_idx;
    logic                    w_hs;
    logic                    w_out_valid;
    logic [IB_WID_W-1:0]     w_out_wid;
    inst_t                   w_out_inst;

    for (genvar g = 0; g < IB_NUM_WARPS; g++) begin : g_q
        assign w_rsv[g]   = bus.rsv_valid   && (bus.rsv_warp_id   == IB_WID_W'(g));
        assign w_wr[g]    = bus.in_valid    && (bus.in_warp_id    == IB_WID_W'(g));
        assign w_flush[g] = bus.flush_valid && (bus.flush_warp_id == IB_WID_W'(g));
        assign w_rd[g]    = w_hs && (w_win == IB_WID_W'(g));

        gelato_ibuffer_queue #(.DEPTH(DEPTH)) u_queue (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_en        (rdy),
            .i_rsv       (w_rsv[g]),
            .i_wr        (w_wr[g]),
            .i_data      (bus.in_inst),
            .i_rd        (w_rd[g]),
            .i_flush     (w_flush[g]),
            .o_head      (w_head[g]),
            .o_empty     (w_empty[g]),
            .o_full      (w_full[g]),
            .o_no_credit (w_no_credit[g])
        );
    end

    // A warp being flushed this cycle must not be offered to issue
    assign w_cand = ~w_empty & ~w_flush & {IB_NUM_WARPS{rdy}};
    assign w_hs   = w_found & bus.out_ready;

    // First candidate at or after the round-robin pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = {IB_WID_W{1'b0}};
        w_idx   = {IB_WID_W{1'b0}};
        for (int i = 0; i < IB_NUM_WARPS; i++) begin
            w_idx = IB_WID_W'((int'(r_rr) + i) % IB_NUM_WARPS);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Issue port is all-zero whenever nothing is offered
    always_comb begin
        w_out_valid = w_found;
        if (w_found) begin
            w_out_wid  = w_win;
            w_out_inst = w_head[w_win];
        end else begin
            w_out_wid  = {IB_WID_W{1'b0}};
            w_out_inst = inst_t'({IB_INST_WIDTH{1'b0}});
        end
    end

    // Round-robin pointer only advances past a warp that actually issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= {IB_WID_W{1'b0}};
        end else if (w_hs) begin
            r_rr <= warp_inc(w_win);
        end
    end

    assign bus.warp_full   = w_full;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_warp_id = w_out_wid;
    assign bus.out_inst    = w_out_inst;

    gelato_ibuffer_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rsv_valid   (bus.rsv_valid),
        .rsv_warp_id (bus.rsv_warp_id),
        .in_valid    (bus.in_valid),
        .in_warp_id  (bus.in_warp_id),
        .warp_full   (w_full),
        .no_credit   (w_no_credit)
    );

endmodule

// File: tb/tb_gelato_ibuffer.sv
// Scoreboard bench for gelato_ibuffer: surviving arrivals are queued in expected
// issue order and compared against each issue handshake.
module tb_gelato_ibuffer;
    import gelato_ibuffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;

    always #5 clk = ~clk;

    gelato_ibuffer_if bus();

    gelato_ibuffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    typedef struct packed {
        logic [IB_WID_W-1:0]      w;
        logic [IB_INST_WIDTH-1:0] inst;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic idle();
        bus.rsv_valid     = 1'b0;
        bus.rsv_warp_id   = '0;
        bus.in_valid      = 1'b0;
        bus.in_warp_id    = '0;
        bus.in_inst       = '0;
        bus.flush_valid   = 1'b0;
        bus.flush_warp_id = '0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic drive_rsv(input int w);
        bus.rsv_valid   = 1'b1;
        bus.rsv_warp_id = IB_WID_W'(w);
    endtask

    task automatic drive_arr(input int w, input logic [IB_INST_WIDTH-1:0] v, input bit keep);
        exp_t e;
        bus.in_valid   = 1'b1;
        bus.in_warp_id = IB_WID_W'(w);
        bus.in_inst    = v;
        if (keep) begin
            e.w    = IB_WID_W'(w);
            e.inst = v;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        drive_rsv(3);
        drive_arr(3, 'hDEAD, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nchk++;
            if ({bus.out_valid, bus.out_warp_id, bus.out_inst, bus.warp_full} !== '0) begin
                nerr++;
                $display("FAIL reset_outputs: got valid=%0b wid=%0d inst=%h full=%b, want all 0",
                         bus.out_valid, bus.out_warp_id, bus.out_inst, bus.warp_full);
            end
        end
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        nchk++;
        if (bus.out_valid !== 1'b0 || bus.warp_full !== 8'h00) begin
            nerr++;
            $display("FAIL reset_release: got valid=%0b full=%b, want 0/00000000", bus.out_valid, bus.warp_full);
        end
        tick();
    endtask

    task automatic test_passthrough();
        exp_t e;
        drive_rsv(3);
        bus.out_ready = 1'b1;
        tick();
        drive_arr(3, 'hA5, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        nchk++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL pt_no_bypass: got valid=%0b, want 0", bus.out_valid);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        if (sb.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL pt_issue: scoreboard empty");
        end else begin
            e = sb.pop_front();
            nchk++;
            if (bus.out_valid !== 1'b1 || bus.out_warp_id !== e.w || bus.out_inst !== e.inst) begin
                nerr++;
                $display("FAIL pt_issue: got v=%0b w=%0d inst=%h, want v=1 w=%0d inst=%h",
                         bus.out_valid, bus.out_warp_id, bus.out_inst, e.w, e.inst);
            end
        end
        tick();
        @(negedge clk);
        nchk++;
        if (bus.out_valid !== 1'b0 || bus.warp_full !== 8'h00) begin
            nerr++;
            $display("FAIL pt_empty: got valid=%0b full=%b, want 0/00000000", bus.out_valid, bus.warp_full);
        end
        tick();
    endtask

    task automatic test_credit_full();
        exp_t e;
        drive_rsv(1);
        tick();
        drive_rsv(1);
        tick();
        drive_rsv(1);
        @(negedge clk);
        nchk++;
        if (bus.warp_full !== 8'h02) begin
            nerr++;
            $display("FAIL cf_full: got %b, want 00000010", bus.warp_full);
        end
        tick();
        @(negedge clk);
        nchk++;
        if (bus.warp_full !== 8'h02) begin
            nerr++;
            $display("FAIL cf_third_ignored: got %b, want 00000010", bus.warp_full);
        end
        tick();
        drive_arr(1, 'hB1, 1'b1);
        tick();
        drive_arr(1, 'hB2, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.out_ready = (k == 0);
            @(negedge clk);
            nchk++;
            if (bus.warp_full !== ((k == 0) ? 8'h02 : 8'h00)) begin
                nerr++;
                $display("FAIL cf_release%0d: got %b, want %b", k, bus.warp_full, (k == 0) ? 8'h02 : 8'h00);
            end
            if (k == 0) begin
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL cf_issue: scoreboard empty");
                end else begin
                    e = sb.pop_front();
                    nchk++;
                    if (bus.out_valid !== 1'b1 || bus.out_warp_id !== e.w || bus.out_inst !== e.inst) begin
                        nerr++;
                        $display("FAIL cf_issue: got v=%0b w=%0d inst=%h, want v=1 w=%0d inst=%h",
                                 bus.out_valid, bus.out_warp_id, bus.out_inst, e.w, e.inst);
                    end
                end
            end
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        if (sb.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL cf_issue2: scoreboard empty");
        end else begin
            e = sb.pop_front();
            nchk++;
            if (bus.out_valid !== 1'b1 || bus.out_warp_id !== e.w || bus.out_inst !== e.inst) begin
                nerr++;
                $display("FAIL cf_issue2: got v=%0b w=%0d inst=%h, want v=1 w=%0d inst=%h",
                         bus.out_valid, bus.out_warp_id, bus.out_inst, e.w, e.inst);
            end
        end
        tick();
    endtask

    task automatic test_round_robin();
        int   ws[6] = '{0, 2, 5, 0, 2, 5};
        exp_t e;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive_rsv(ws[i]);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive_arr(ws[i], IB_INST_WIDTH'(32'h100 + i), 1'b1);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nchk++;
            if (bus.out_valid !== 1'b1 || bus.out_warp_id !== 3'd0 || bus.out_inst !== 96'h100) begin
                nerr++;
                $display("FAIL rr_hold%0d: got v=%0b w=%0d inst=%h, want v=1 w=0 inst=100",
                         k, bus.out_valid, bus.out_warp_id, bus.out_inst);
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (sb.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL rr_order%0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                nchk++;
                if (bus.out_valid !== 1'b1 || bus.out_warp_id !== e.w || bus.out_inst !== e.inst) begin
                    nerr++;
                    $display("FAIL rr_order%0d: got v=%0b w=%0d inst=%h, want v=1 w=%0d inst=%h",
                             i, bus.out_valid, bus.out_warp_id, bus.out_inst, e.w, e.inst);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush_inflight();
        exp_t e;
        drive_rsv(4);
        tick();
        drive_rsv(4);
        drive_arr(4, 'h44, 1'b0);
        tick();
        bus.flush_valid   = 1'b1;
        bus.flush_warp_id = 3'd4;
        bus.out_ready     = 1'b1;
        @(negedge clk);
        nchk++;
        if (bus.out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL fi_flush_cycle: got valid=%0b w=%0d, want 0", bus.out_valid, bus.out_warp_id);
        end
        tick();
        for (int s = 0; s < 3; s++) begin
            if (s == 0) drive_arr(4, 'h11, 1'b0);
            if (s == 1) drive_rsv(4);
            if (s == 2) drive_arr(4, 'h22, 1'b1);
            bus.out_ready = 1'b1;
            @(negedge clk);
            nchk++;
            if (bus.out_valid !== 1'b0 || bus.warp_full !== 8'h00) begin
                nerr++;
                $display("FAIL fi_step%0d: got valid=%0b inst=%h full=%b, want 0/-/00000000",
                         s, bus.out_valid, bus.out_inst, bus.warp_full);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        if (sb.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL fi_issue: scoreboard empty");
        end else begin
            e = sb.pop_front();
            nchk++;
            if (bus.out_valid !== 1'b1 || bus.out_warp_id !== e.w || bus.out_inst !== e.inst) begin
                nerr++;
                $display("FAIL fi_issue: got v=%0b w=%0d inst=%h, want v=1 w=%0d inst=%h",
                         bus.out_valid, bus.out_warp_id, bus.out_inst, e.w, e.inst);
            end
        end
        tick();
        @(negedge clk);
        nchk++;
        if (bus.out_valid !== 1'b0 || bus.warp_full !== 8'h00) begin
            nerr++;
            $display("FAIL fi_drained: got valid=%0b full=%b, want 0/00000000", bus.out_valid, bus.warp_full);
        end
        tick();
    endtask

    task automatic test_flush_arrival();
        exp_t e;
        pulse_reset();
        drive_rsv(2);
        tick();
        drive_rsv(2);
        drive_arr(2, 'h21, 1'b0);
        tick();
        drive_rsv(6);
        tick();
        drive_arr(6, 'h61, 1'b1);
        tick();
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                bus.flush_valid   = 1'b1;
                bus.flush_warp_id = 3'd2;
                drive_arr(2, 'h2F, 1'b0);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (sb.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL fa_issue%0d: scoreboard empty", s);
            end else begin
                e = sb.pop_front();
                nchk++;
                if (bus.out_valid !== 1'b1 || bus.out_warp_id !== e.w || bus.out_inst !== e.inst) begin
                    nerr++;
                    $display("FAIL fa_issue%0d: got v=%0b w=%0d inst=%h, want v=1 w=%0d inst=%h",
                             s, bus.out_valid, bus.out_warp_id, bus.out_inst, e.w, e.inst);
                end
            end
            tick();
            if (s == 0) begin
                @(negedge clk);
                nchk++;
                if (bus.out_valid !== 1'b0 || bus.warp_full !== 8'h00) begin
                    nerr++;
                    $display("FAIL fa_cleared: got valid=%0b w=%0d full=%b, want 0/-/00000000",
                             bus.out_valid, bus.out_warp_id, bus.warp_full);
                end
                tick();
                drive_rsv(2);
                tick();
                drive_arr(2, 'h2A, 1'b1);
                tick();
            end
        end
    endtask

    task automatic test_rdy_stall_reset();
        exp_t e;
        pulse_reset();
        drive_rsv(3);
        tick();
        drive_arr(3, 'h33, 1'b1);
        drive_rsv(7);
        tick();
        drive_rsv(7);
        drive_arr(7, 'h71, 1'b1);
        tick();
        drive_arr(7, 'h72, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            rdy = !(i >= 1 && i <= 4);
            bus.out_ready = 1'b1;
            if (!rdy) begin
                drive_rsv(0);
                drive_arr(7, 'hFF, 1'b0);
                bus.flush_valid   = 1'b1;
                bus.flush_warp_id = 3'd7;
            end
            @(negedge clk);
            if (!rdy) begin
                nchk++;
                if (bus.out_valid !== 1'b0 || bus.warp_full !== 8'h80) begin
                    nerr++;
                    $display("FAIL stall%0d: got valid=%0b full=%b, want 0/10000000",
                             i, bus.out_valid, bus.warp_full);
                end
            end else if (sb.size() == 0) begin
                nchk++; nerr++;
                $display("FAIL stall_issue%0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                nchk++;
                if (bus.out_valid !== 1'b1 || bus.out_warp_id !== e.w || bus.out_inst !== e.inst) begin
                    nerr++;
                    $display("FAIL stall_issue%0d: got v=%0b w=%0d inst=%h, want v=1 w=%0d inst=%h",
                             i, bus.out_valid, bus.out_warp_id, bus.out_inst, e.w, e.inst);
                end
            end
            tick();
        end
        rdy = 1'b1;
        drive_rsv(5);
        tick();
        drive_arr(5, 'h55, 1'b0);
        tick();
        @(negedge clk);
        nchk++;
        if (bus.out_valid !== 1'b1 || bus.out_inst !== 96'h55) begin
            nerr++;
            $display("FAIL ar_setup: got valid=%0b inst=%h, want 1/55", bus.out_valid, bus.out_inst);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nchk++;
        if ({bus.out_valid, bus.out_warp_id, bus.out_inst, bus.warp_full} !== '0) begin
            nerr++;
            $display("FAIL ar_async: got valid=%0b wid=%0d inst=%h full=%b, want all 0",
                     bus.out_valid, bus.out_warp_id, bus.out_inst, bus.warp_full);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        nchk++;
        if (bus.out_valid !== 1'b0 || bus.warp_full !== 8'h00) begin
            nerr++;
            $display("FAIL ar_after: got valid=%0b full=%b, want 0/00000000", bus.out_valid, bus.warp_full);
        end
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_passthrough();
        test_credit_full();
        test_round_robin();
        test_flush_inflight();
        test_flush_arrival();
        test_rdy_stall_reset();
        nchk++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL sb_leftover: got %0d unissued, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
